// File: rtl/code_conv_seq.sv
`default_nettype none
// ============================================================================
// Module   : code_conv_seq
// Brief    : Sequenced binary -> Gray / excess-code converter. It captures an
//            operand and converts it forward in one cycle. It then recovers
//            the binary value from the Gray form bit-serially (MSB first) and
//            from the excess form in one step. Finally it flags any
//            round-trip mismatch and pulses stop.
// Revision : 1.0 - initial release
// ============================================================================
module code_conv_seq #(
    parameter int WIDTH     = 4,
    parameter int XS_OFFSET = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] gout,
    output logic [WIDTH-1:0] xsout,
    output logic [WIDTH-1:0] bout1,
    output logic [WIDTH-1:0] bout2,
    output logic             xs_ovf,
    output logic             err,
    output logic             busy,
    output logic             stop
);

    localparam int             IW        = $clog2(WIDTH);
    localparam logic [IW-1:0]  c_IDX_MSB = IW'(WIDTH - 1);
    localparam logic [WIDTH:0] c_XS_EXT  = (WIDTH + 1)'(XS_OFFSET);
    localparam logic [WIDTH-1:0] c_XS    = WIDTH'(XS_OFFSET);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FWD  = 2'd1,
        S_REV  = 2'd2,
        S_DONE = 2'd3
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [WIDTH-1:0] r_din_q;
    logic [IW-1:0]    r_idx;

    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_above;
    logic             w_rev_bit;

    // Forward sum with carry, and the next serial Gray->binary bit.
    // Shifting a zero-extended copy of bout1 by idx+1 yields bout1[idx+1],
    // or the extension zero at the MSB, so the MSB step reduces to gout[MSB].
    always_comb begin
        w_sum     = {1'b0, r_din_q} + c_XS_EXT;
        w_above   = {1'b0, bout1} >> ({1'b0, r_idx} + {{IW{1'b0}}, 1'b1});
        w_rev_bit = w_above[0] ^ gout[r_idx];
    end

    // Next-state decode.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (start) w_state_nxt = S_FWD;
            S_FWD:   w_state_nxt = S_REV;
            S_REV:   if (r_idx == '0) w_state_nxt = S_DONE;
            S_DONE:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Status is decoded from registered state only.
    assign busy = (r_state != S_IDLE);
    assign stop = (r_state == S_DONE);

    // State register and datapath registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_din_q <= '0;
            r_idx   <= '0;
            gout    <= '0;
            xsout   <= '0;
            bout1   <= '0;
            bout2   <= '0;
            xs_ovf  <= 1'b0;
            err     <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_IDLE: begin
                    if (start) r_din_q <= din;
                end
                S_FWD: begin
                    gout   <= r_din_q ^ (r_din_q >> 1);
                    xsout  <= w_sum[WIDTH-1:0];
                    xs_ovf <= w_sum[WIDTH];
                    bout1  <= '0;
                    bout2  <= '0;
                    err    <= 1'b0;
                    r_idx  <= c_IDX_MSB;
                end
                S_REV: begin
                    bout1[r_idx] <= w_rev_bit;
                    // Excess decode needs only one step; do it on the first pass.
                    if (r_idx == c_IDX_MSB) bout2 <= xsout - c_XS;
                    if (r_idx != '0) r_idx <= r_idx - 1'b1;
                end
                S_DONE: begin
                    // Compare only once both recovered words are complete.
                    err <= (bout1 != r_din_q) | (bout2 != r_din_q);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_code_conv_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_code_conv_seq
// Brief    : Directed testbench for code_conv_seq (WIDTH=4 and WIDTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_code_conv_seq;

    logic       clk = 1'b0;
    logic       rst, start, start8;
    logic [3:0] din, gout, xsout, bout1, bout2;
    logic       xs_ovf, err, busy, stop;
    logic [7:0] din8, gout8, xsout8, bout1_8, bout2_8;
    logic       xs_ovf8, err8, busy8, stop8;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    code_conv_seq #(.WIDTH(4), .XS_OFFSET(3)) dut (
        .clk(clk), .rst(rst), .start(start), .din(din),
        .gout(gout), .xsout(xsout), .bout1(bout1), .bout2(bout2),
        .xs_ovf(xs_ovf), .err(err), .busy(busy), .stop(stop)
    );

    code_conv_seq #(.WIDTH(8), .XS_OFFSET(3)) dut8 (
        .clk(clk), .rst(rst), .start(start8), .din(din8),
        .gout(gout8), .xsout(xsout8), .bout1(bout1_8), .bout2(bout2_8),
        .xs_ovf(xs_ovf8), .err(err8), .busy(busy8), .stop(stop8)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Counts edges until stop is seen (bounded).
    task automatic wait_stop4(output int cyc);
        cyc = 0;
        while (stop !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    endtask

    task automatic wait_stop8(output int cyc);
        cyc = 0;
        while (stop8 !== 1'b1 && cyc < 40) begin tick(); cyc++; end
    endtask

    task automatic test_reset;
        rst = 1'b1; start = 1'b1; din = 4'hF; start8 = 1'b1; din8 = 8'hFF;
        tick(); tick();
        tests++; if ({gout, xsout, bout1, bout2, xs_ovf, err, busy, stop} !== 20'h0) begin
            fails++; $display("FAIL reset_w4 got=%h exp=0", {gout, xsout, bout1, bout2, xs_ovf, err, busy, stop}); end
        tests++; if ({gout8, xsout8, bout1_8, bout2_8, xs_ovf8, err8, busy8, stop8} !== 36'h0) begin
            fails++; $display("FAIL reset_w8 got=%h exp=0", {gout8, xsout8, bout1_8, bout2_8, xs_ovf8, err8, busy8, stop8}); end
        rst = 1'b0; start = 1'b0; start8 = 1'b0; din = 4'h0; din8 = 8'h00;
        tick();
    endtask

    task automatic test_nominal;
        int busy_cnt, stop_early;
        busy_cnt = 0; stop_early = 0;
        din = 4'h5; start = 1'b1;
        tick();                              // edge 0
        start = 1'b0; din = 4'hA;            // operand change must not matter
        if (busy) busy_cnt++;
        tick();                              // edge 1
        if (busy) busy_cnt++;
        if (stop) stop_early++;
        tests++; if (gout !== 4'h7) begin fails++; $display("FAIL nom_gout got=%h exp=7", gout); end
        tests++; if (xsout !== 4'h8) begin fails++; $display("FAIL nom_xsout got=%h exp=8", xsout); end
        tests++; if (xs_ovf !== 1'b0) begin fails++; $display("FAIL nom_ovf got=%b exp=0", xs_ovf); end
        for (int i = 2; i <= 5; i++) begin
            tick();
            if (busy) busy_cnt++;
            if (i < 5 && stop) stop_early++;
        end
        tests++; if (stop !== 1'b1) begin fails++; $display("FAIL nom_stop got=%b exp=1", stop); end
        tests++; if (stop_early !== 0) begin fails++; $display("FAIL nom_stop_early got=%0d exp=0", stop_early); end
        tests++; if (bout1 !== 4'h5) begin fails++; $display("FAIL nom_bout1 got=%h exp=5", bout1); end
        tests++; if (bout2 !== 4'h5) begin fails++; $display("FAIL nom_bout2 got=%h exp=5", bout2); end
        tick();                              // edge 6
        tests++; if (stop !== 1'b0) begin fails++; $display("FAIL nom_stop_len got=%b exp=0", stop); end
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL nom_err got=%b exp=0", err); end
        tests++; if (busy !== 1'b0 || busy_cnt !== 6) begin
            fails++; $display("FAIL nom_busy got=%b/%0d exp=0/6", busy, busy_cnt); end
    endtask

    task automatic test_wrap;
        int c;
        din = 4'hD; start = 1'b1; tick(); start = 1'b0; tick();
        tests++; if (gout !== 4'hB) begin fails++; $display("FAIL wrap_gout got=%h exp=b", gout); end
        tests++; if (xsout !== 4'h0) begin fails++; $display("FAIL wrap_xsout got=%h exp=0", xsout); end
        tests++; if (xs_ovf !== 1'b1) begin fails++; $display("FAIL wrap_ovf got=%b exp=1", xs_ovf); end
        wait_stop4(c);
        tests++; if (c !== 4) begin fails++; $display("FAIL wrap_lat got=%0d exp=4", c); end
        tests++; if (bout2 !== 4'hD) begin fails++; $display("FAIL wrap_bout2 got=%h exp=d", bout2); end
        tick();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL wrap_err got=%b exp=0", err); end
        din = 4'hF; start = 1'b1; tick(); start = 1'b0; tick();
        tests++; if (gout !== 4'h8) begin fails++; $display("FAIL f_gout got=%h exp=8", gout); end
        wait_stop4(c);
        tests++; if (bout1 !== 4'hF) begin fails++; $display("FAIL f_bout1 got=%h exp=f", bout1); end
        tick();
    endtask

    task automatic test_back_to_back;
        int c;
        din = 4'h0; start = 1'b1;
        tick();
        wait_stop4(c);
        tests++; if (c !== 5) begin fails++; $display("FAIL b2b_first_lat got=%0d exp=5", c); end
        for (int v = 0; v < 16; v++) begin
            tests++; if (bout1 !== 4'(v) || bout2 !== 4'(v)) begin
                fails++; $display("FAIL b2b_data v=%0d got=%h/%h exp=%h", v, bout1, bout2, 4'(v)); end
            tick();
            tests++; if (err !== 1'b0) begin fails++; $display("FAIL b2b_err v=%0d got=%b exp=0", v, err); end
            if (v < 15) begin
                din = 4'(v + 1);
                wait_stop4(c);
                tests++; if (c !== 6) begin fails++; $display("FAIL b2b_period v=%0d got=%0d exp=6", v + 1, c); end
            end else begin
                start = 1'b0;
            end
        end
        tick();
    endtask

    task automatic test_ignore_busy;
        int c;
        din = 4'h3; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();              // now mid-REV
        start = 1'b1; din = 4'h9; tick(); start = 1'b0;
        wait_stop4(c);
        tests++; if (c !== 1) begin fails++; $display("FAIL ign_lat got=%0d exp=1", c); end
        tests++; if (bout1 !== 4'h3 || gout !== 4'h2) begin
            fails++; $display("FAIL ign_data got=%h/%h exp=3/2", bout1, gout); end
        tick(); tick();
        tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_queued got=%b exp=0", busy); end
    endtask

    task automatic test_reset_mid;
        int c, stops;
        stops = 0;
        din = 4'h6; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();              // third REV cycle
        rst = 1'b1; tick(); rst = 1'b0;
        tests++; if ({gout, xsout, bout1, bout2, xs_ovf, err, busy, stop} !== 20'h0) begin
            fails++; $display("FAIL rstmid_out got=%h exp=0", {gout, xsout, bout1, bout2, xs_ovf, err, busy, stop}); end
        for (int i = 0; i < 10; i++) begin tick(); if (stop || busy) stops++; end
        tests++; if (stops !== 0) begin fails++; $display("FAIL rstmid_stop got=%0d exp=0", stops); end
        din = 4'hC; start = 1'b1; tick(); start = 1'b0; tick();
        tests++; if (gout !== 4'hA || xsout !== 4'hF) begin
            fails++; $display("FAIL rstmid_fwd got=%h/%h exp=a/f", gout, xsout); end
        wait_stop4(c);
        tests++; if (c !== 4 || bout1 !== 4'hC || bout2 !== 4'hC) begin
            fails++; $display("FAIL rstmid_rev got=%0d/%h/%h exp=4/c/c", c, bout1, bout2); end
        tick();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL rstmid_err got=%b exp=0", err); end
    endtask

    task automatic test_self_check;
        int c;
        din = 4'h9; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick(); tick();      // last REV cycle
        force dut.bout1 = 4'b1000;           // bit 0 wrong
        tick();
        tests++; if (stop !== 1'b1) begin fails++; $display("FAIL sc_stop got=%b exp=1", stop); end
        tick();
        release dut.bout1;
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL sc_err got=%b exp=1", err); end
        tick(); tick();
        tests++; if (err !== 1'b1) begin fails++; $display("FAIL sc_err_hold got=%b exp=1", err); end
        din = 4'h9; start = 1'b1; tick(); start = 1'b0; tick();
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL sc_err_clr got=%b exp=0", err); end
        wait_stop4(c);
        tick();
        tests++; if (err !== 1'b0 || bout1 !== 4'h9) begin
            fails++; $display("FAIL sc_clean got=%b/%h exp=0/9", err, bout1); end
    endtask

    task automatic test_width8;
        int c;
        din8 = 8'hA5; start8 = 1'b1; tick(); start8 = 1'b0; din8 = 8'h00; tick();
        tests++; if (gout8 !== 8'hF7 || xsout8 !== 8'hA8 || xs_ovf8 !== 1'b0) begin
            fails++; $display("FAIL w8_fwd got=%h/%h/%b exp=f7/a8/0", gout8, xsout8, xs_ovf8); end
        wait_stop8(c);
        tests++; if (c !== 8) begin fails++; $display("FAIL w8_lat got=%0d exp=8", c); end
        tests++; if (bout1_8 !== 8'hA5 || bout2_8 !== 8'hA5) begin
            fails++; $display("FAIL w8_rev got=%h/%h exp=a5/a5", bout1_8, bout2_8); end
        tick();
        din8 = 8'hFE; start8 = 1'b1; tick(); start8 = 1'b0; tick();
        tests++; if (xsout8 !== 8'h01 || xs_ovf8 !== 1'b1) begin
            fails++; $display("FAIL w8_wrap got=%h/%b exp=01/1", xsout8, xs_ovf8); end
        wait_stop8(c);
        tests++; if (bout2_8 !== 8'hFE || bout1_8 !== 8'hFE) begin
            fails++; $display("FAIL w8_wrap_rev got=%h/%h exp=fe/fe", bout1_8, bout2_8); end
        tick();
        tests++; if (err8 !== 1'b0) begin fails++; $display("FAIL w8_err got=%b exp=0", err8); end
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; start8 = 1'b0; din = '0; din8 = '0;
        test_reset();
        test_nominal();
        test_wrap();
        test_back_to_back();
        test_ignore_busy();
        test_reset_mid();
        test_self_check();
        test_width8();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
